// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: round-robin ALU/LSU grant onto
// the single write port, plus a per-register busy scoreboard.
module rf_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            reserve_valid_i,
  input  logic [4:0]      reserve_addr_i,
  input  logic            alu_valid_i,
  output logic            alu_ready_o,
  input  logic [4:0]      alu_addr_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            lsu_valid_i,
  output logic            lsu_ready_o,
  input  logic [4:0]      lsu_addr_i,
  input  logic [XLEN-1:0] lsu_data_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  input  logic [4:0]      query_addr1_i,
  input  logic [4:0]      query_addr2_i,
  output logic            busy1_o,
  output logic            busy2_o
);

  logic            last_lsu_q, last_lsu_d;
  logic            we_q, we_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [31:0]     busy_q, busy_d;
  logic            alu_gnt, lsu_gnt;

  // On a tie the requester not granted most recently wins.
  always_comb begin
    alu_gnt = !rst_i && alu_valid_i &&
              (!lsu_valid_i || last_lsu_q);
    lsu_gnt = !rst_i && lsu_valid_i &&
              (!alu_valid_i || !last_lsu_q);
  end

  always_comb begin
    last_lsu_d = last_lsu_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (alu_gnt) last_lsu_d = 1'b0;
    if (lsu_gnt) last_lsu_d = 1'b1;
    if (alu_gnt && alu_addr_i != 5'd0) begin
      we_d    = 1'b1;
      waddr_d = alu_addr_i;
      wdata_d = alu_data_i;
    end else if (lsu_gnt && lsu_addr_i != 5'd0) begin
      we_d    = 1'b1;
      waddr_d = lsu_addr_i;
      wdata_d = lsu_data_i;
    end
  end

  // A new reservation overrides the clear from a landing write.
  always_comb begin
    busy_d = busy_q;
    if (we_q) busy_d[waddr_q] = 1'b0;
    if (reserve_valid_i && reserve_addr_i != 5'd0)
      busy_d[reserve_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_lsu_q <= 1'b1;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= '0;
    end else begin
      last_lsu_q <= last_lsu_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign alu_ready_o = alu_gnt;
  assign lsu_ready_o = lsu_gnt;
  assign rf_we_o     = we_q;
  assign rf_waddr_o  = waddr_q;
  assign rf_wdata_o  = wdata_q;
  assign busy1_o     = busy_q[query_addr1_i];
  assign busy2_o     = busy_q[query_addr2_i];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a reference model and a
// queue of expected register-file writes.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_v;
  logic [4:0]  res_a;
  logic        alu_v, lsu_v;
  logic        alu_rdy, lsu_rdy;
  logic [4:0]  alu_a, lsu_a;
  logic [31:0] alu_d, lsu_d;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  q1, q2;
  logic        b1, b2;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] m_busy;
  logic        m_last_lsu;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.XLEN(32)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .reserve_valid_i (res_v),
    .reserve_addr_i  (res_a),
    .alu_valid_i     (alu_v),
    .alu_ready_o     (alu_rdy),
    .alu_addr_i      (alu_a),
    .alu_data_i      (alu_d),
    .lsu_valid_i     (lsu_v),
    .lsu_ready_o     (lsu_rdy),
    .lsu_addr_i      (lsu_a),
    .lsu_data_i      (lsu_d),
    .rf_we_o         (we),
    .rf_waddr_o      (waddr),
    .rf_wdata_o      (wdata),
    .query_addr1_i   (q1),
    .query_addr2_i   (q2),
    .busy1_o         (b1),
    .busy2_o         (b2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    res_v = 1'b0; res_a = '0;
    alu_v = 1'b0; alu_a = '0; alu_d = '0;
    lsu_v = 1'b0; lsu_a = '0; lsu_d = '0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_busy     = '0;
    m_last_lsu = 1'b1;
  endtask

  // Check one cycle against the model, then advance the model.
  task automatic tick(input string tag);
    logic ea, el;
    wr_t  e;
    logic clr_v;
    logic [4:0] clr_a;
    #1;
    ea = alu_v && (!lsu_v || m_last_lsu);
    el = lsu_v && (!alu_v || !m_last_lsu);
    chk({tag, ".alu_rdy"}, 32'(alu_rdy), 32'(ea));
    chk({tag, ".lsu_rdy"}, 32'(lsu_rdy), 32'(el));
    clr_v = 1'b0;
    clr_a = '0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".we"}, 32'(we), 32'd1);
      chk({tag, ".waddr"}, 32'(waddr), 32'(e.a));
      chk({tag, ".wdata"}, wdata, e.d);
      clr_v = 1'b1;
      clr_a = e.a;
    end else begin
      chk({tag, ".we"}, 32'(we), 32'd0);
    end
    chk({tag, ".busy1"}, 32'(b1), 32'(m_busy[q1]));
    chk({tag, ".busy2"}, 32'(b2), 32'(m_busy[q2]));
    if (clr_v) m_busy[clr_a] = 1'b0;
    if (res_v && res_a != 5'd0) m_busy[res_a] = 1'b1;
    if (ea) begin
      m_last_lsu = 1'b0;
      if (alu_a != 5'd0) exp_q.push_back('{alu_a, alu_d});
    end
    if (el) begin
      m_last_lsu = 1'b1;
      if (lsu_a != 5'd0) exp_q.push_back('{lsu_a, lsu_d});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    q1 = 5'd0; q2 = 5'd0;
    rst = 1'b1;
    model_reset();
    alu_v = 1'b1; lsu_v = 1'b1;
    #2;
    chk("rst.alu_rdy", 32'(alu_rdy), 32'd0);
    chk("rst.lsu_rdy", 32'(lsu_rdy), 32'd0);
    chk("rst.we", 32'(we), 32'd0);
    chk("rst.waddr", 32'(waddr), 32'd0);
    chk("rst.wdata", wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();

    // single ALU write
    alu_v = 1'b1; alu_a = 5'd5; alu_d = 32'hDEADBEEF;
    q1 = 5'd5;
    tick("alu1");
    idle();
    tick("alu1.wr");
    tick("alu1.done");

    // scoreboard lifecycle on x7
    res_v = 1'b1; res_a = 5'd7; q1 = 5'd7; q2 = 5'd5;
    tick("sb.res");
    idle();
    chk("sb.busy7", 32'(b1), 32'd1);
    lsu_v = 1'b1; lsu_a = 5'd7; lsu_d = 32'h0000_7777;
    tick("sb.lsu");
    idle();
    tick("sb.wr");
    chk("sb.clear7", 32'(b1), 32'd0);
    tick("sb.after");

    // contention: ALU wins the first tie
    alu_v = 1'b1; alu_a = 5'd1; alu_d = 32'h11;
    lsu_v = 1'b1; lsu_a = 5'd2; lsu_d = 32'h22;
    q1 = 5'd1; q2 = 5'd2;
    for (int i = 0; i < 4; i++) tick("tie");
    idle();
    tick("tie.drain");

    // set/clear collision on x9
    res_v = 1'b1; res_a = 5'd9; q1 = 5'd9;
    tick("col.res");
    idle();
    alu_v = 1'b1; alu_a = 5'd9; alu_d = 32'h9999;
    tick("col.alu");
    idle();
    res_v = 1'b1; res_a = 5'd9;
    tick("col.both");
    idle();
    chk("col.busy9", 32'(b1), 32'd1);
    tick("col.after");

    // x0 handling
    res_v = 1'b1; res_a = 5'd0; q1 = 5'd0;
    alu_v = 1'b1; alu_a = 5'd0; alu_d = 32'hFFFFFFFF;
    tick("x0.req");
    idle();
    chk("x0.we", 32'(we), 32'd0);
    chk("x0.busy", 32'(b1), 32'd0);
    alu_v = 1'b1; alu_a = 5'd3; alu_d = 32'h33;
    lsu_v = 1'b1; lsu_a = 5'd4; lsu_d = 32'h44;
    #1;
    chk("x0.tie_lsu", 32'(lsu_rdy), 32'd1);
    tick("x0.tie");
    idle();
    tick("x0.drain");

    // mid-operation reset while a write to x3 lands
    res_v = 1'b1; res_a = 5'd3; q1 = 5'd3;
    tick("mr.res");
    idle();
    alu_v = 1'b1; alu_a = 5'd3; alu_d = 32'h3333;
    tick("mr.alu");
    idle();
    #1;
    chk("mr.we_pre", 32'(we), 32'd1);
    chk("mr.busy_pre", 32'(b1), 32'd1);
    alu_v = 1'b1; lsu_v = 1'b1;
    rst = 1'b1;
    #1;
    chk("mr.we", 32'(we), 32'd0);
    chk("mr.busy", 32'(b1), 32'd0);
    chk("mr.alu_rdy", 32'(alu_rdy), 32'd0);
    chk("mr.lsu_rdy", 32'(lsu_rdy), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    alu_a = 5'd10; alu_d = 32'hA;
    lsu_a = 5'd11; lsu_d = 32'hB;
    #1;
    chk("mr.first_alu", 32'(alu_rdy), 32'd1);
    tick("mr.tie");
    idle();
    tick("mr.drain");
    tick("mr.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
